// File: rtl/udp_main.sv
// ---------------------------------------------------------------------------
// udp_main : ingress classifier at the front of the UDP receive path.
//
// Takes one whole Ethernet frame per cycle as a wide MSB-first vector
// (byte k = eth_frame[FRAME_WIDTH-1-8k -: 8]), flags IPv4 frames, validates
// the IPv4 header, detects UDP, extracts the UDP ports and counts frames.
//
// Optional feature macro:
//   UDP_MAIN_CSUM_EN  - when defined, ip_hdr_ok also requires a correct IPv4
//                       header checksum; when undefined no checksum logic is
//                       built.
//
// Ports:
//   main_clk      in   sole clock, rising edge
//   main_rst      in   asynchronous active-low reset
//   eth_frame     in   [FRAME_WIDTH] frame vector, MSB-first
//   frame_valid   in   eth_frame valid this cycle
//   frame_ready   out  block can accept a frame (1 whenever out of reset)
//   result_valid  out  one-cycle strobe per accepted frame
//   valid_ipv4    out  strobe with result_valid when EtherType == 0x0800
//   ip_hdr_ok     out  IPv4 header passed checks (qualified by result_valid)
//   is_udp        out  UDP datagram detected (qualified by result_valid)
//   udp_src_port  out  [16] UDP source port, held until next result
//   udp_dst_port  out  [16] UDP destination port, held until next result
//   frame_count   out  [32] accepted frame count, wraps
//
// Handshake: a frame transfers on the rising edge where frame_valid and
// frame_ready are both 1. frame_ready never drops outside reset, so frames
// may arrive back-to-back; there is no backpressure on the result side.
// Results appear one cycle after acceptance for exactly one cycle.
// ---------------------------------------------------------------------------
module udp_main #(
  parameter int FRAME_WIDTH = 12000
) (
  input  logic                   main_clk,
  input  logic                   main_rst,
  input  logic [FRAME_WIDTH-1:0] eth_frame,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic                   result_valid,
  output logic                   valid_ipv4,
  output logic                   ip_hdr_ok,
  output logic                   is_udp,
  output logic [15:0]            udp_src_port,
  output logic [15:0]            udp_dst_port,
  output logic [31:0]            frame_count
);

  // Only bytes 0..37 (304 bits) are ever inspected.
  localparam int HDR_BITS = 304;

  // hdr byte k occupies hdr[303-8k -: 8].
  logic [HDR_BITS-1:0] hdr;
  logic [15:0]         ether_type;
  logic [3:0]          ip_version;
  logic [3:0]          ip_ihl;
  logic [7:0]          ip_protocol;
  logic [15:0]         src_port;
  logic [15:0]         dst_port;
  logic                ipv4_hit;
  logic                hdr_ok;
  logic                udp_hit;
  logic                accept;
  logic                csum_ok;
  logic                unused_frame_bits;

  assign hdr         = eth_frame[FRAME_WIDTH-1 -: HDR_BITS];
  assign ether_type  = hdr[207:192];   // bytes 12-13
  assign ip_version  = hdr[191:188];   // byte 14 high nibble
  assign ip_ihl      = hdr[187:184];   // byte 14 low nibble
  assign ip_protocol = hdr[119:112];   // byte 23
  assign src_port    = hdr[31:16];     // bytes 34-35
  assign dst_port    = hdr[15:0];      // bytes 36-37

  // Bits outside the inspected fields are intentionally ignored.
  assign unused_frame_bits = ^eth_frame;

`ifdef UDP_MAIN_CSUM_EN
  // Ones'-complement sum of the ten header words (bytes 14..33). Ten 16-bit
  // words fit in 20 bits; two folds absorb all end-around carries.
  logic [19:0] csum_raw;
  logic [16:0] csum_fold1;
  logic [15:0] csum_fold2;

  always_comb begin
    csum_raw = '0;
    for (int i = 0; i < 10; i++) begin
      csum_raw = csum_raw + {4'b0000, hdr[191-16*i -: 16]};
    end
    csum_fold1 = {1'b0, csum_raw[15:0]} + {13'b0, csum_raw[19:16]};
    csum_fold2 = csum_fold1[15:0] + {15'b0, csum_fold1[16]};
  end

  assign csum_ok = (csum_fold2 == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign ipv4_hit = (ether_type == 16'h0800);
  assign hdr_ok   = ipv4_hit && (ip_version == 4'd4) && (ip_ihl == 4'd5) && csum_ok;
  assign udp_hit  = hdr_ok && (ip_protocol == 8'd17);

  // Ready is simply "out of reset": it drops the instant reset asserts and
  // allows acceptance on the first edge after release.
  assign frame_ready = main_rst;
  assign accept      = frame_valid && frame_ready;

  always_ff @(posedge main_clk or negedge main_rst) begin
    if (!main_rst) begin
      result_valid <= 1'b0;
      valid_ipv4   <= 1'b0;
      ip_hdr_ok    <= 1'b0;
      is_udp       <= 1'b0;
      udp_src_port <= 16'h0000;
      udp_dst_port <= 16'h0000;
      frame_count  <= 32'h0000_0000;
    end else if (accept) begin
      result_valid <= 1'b1;
      valid_ipv4   <= ipv4_hit;
      ip_hdr_ok    <= hdr_ok;
      is_udp       <= udp_hit;
      udp_src_port <= udp_hit ? src_port : 16'h0000;
      udp_dst_port <= udp_hit ? dst_port : 16'h0000;
      frame_count  <= frame_count + 32'd1;
    end else begin
      // Strobes and qualified flags clear; ports and count hold.
      result_valid <= 1'b0;
      valid_ipv4   <= 1'b0;
      ip_hdr_ok    <= 1'b0;
      is_udp       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_main.sv
// ---------------------------------------------------------------------------
// tb_udp_main : self-checking bench for udp_main.
// Frames are driven on the falling edge; the expected result for each
// accepted frame is pushed to exp_q at drive time and popped by the monitor
// shortly after the rising edge that accepts it.
// ---------------------------------------------------------------------------
module tb_udp_main;

  localparam int FW    = 12000;
  localparam int EXP_W = 67;   // {v4, ok, udp, src[16], dst[16], count[32]}

  // ---------------- clock / reset ----------------
  logic          main_clk = 1'b0;
  logic          main_rst;
  logic [FW-1:0] eth_frame;
  logic          frame_valid;
  logic          frame_ready;
  logic          result_valid;
  logic          valid_ipv4;
  logic          ip_hdr_ok;
  logic          is_udp;
  logic [15:0]   udp_src_port;
  logic [15:0]   udp_dst_port;
  logic [31:0]   frame_count;

  always #5 main_clk = ~main_clk;

  udp_main #(.FRAME_WIDTH(FW)) dut (
    .main_clk     (main_clk),
    .main_rst     (main_rst),
    .eth_frame    (eth_frame),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .result_valid (result_valid),
    .valid_ipv4   (valid_ipv4),
    .ip_hdr_ok    (ip_hdr_ok),
    .is_udp       (is_udp),
    .udp_src_port (udp_src_port),
    .udp_dst_port (udp_dst_port),
    .frame_count  (frame_count)
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [31:0]      exp_count = 32'd0;
  logic [15:0]      exp_src = 16'h0;
  logic [15:0]      exp_dst = 16'h0;
  bit               mon_en = 1'b0;
  logic [FW-1:0]    frame_buf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- frame building ----------------
  task automatic clear_frame();
    frame_buf = '0;
  endtask

  task automatic set_byte(input int k, input logic [7:0] v);
    frame_buf[FW-1-8*k -: 8] = v;
  endtask

  function automatic logic [7:0] get_byte(input int k);
    return frame_buf[FW-1-8*k -: 8];
  endfunction

  task automatic set_macs();
    logic [7:0] macs [12] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
                              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int k = 0; k < 12; k++) set_byte(k, macs[k]);
  endtask

  task automatic set_ethertype(input logic [15:0] et);
    set_byte(12, et[15:8]);
    set_byte(13, et[7:0]);
  endtask

  // Ones'-complement folded sum of the ten IPv4 header words.
  function automatic logic [15:0] hdr_sum();
    int unsigned s = 0;
    for (int i = 0; i < 10; i++) s += {get_byte(14 + 2*i), get_byte(15 + 2*i)};
    while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic fix_checksum();
    logic [15:0] s;
    set_byte(24, 8'h00);
    set_byte(25, 8'h00);
    s = ~hdr_sum();
    set_byte(24, s[15:8]);
    set_byte(25, s[7:0]);
  endtask

  // IPv4/UDP frame: 45 00 00 1C 00 00 40 00 40 <proto> <cks> C0A80001 C0A800C7
  task automatic build_ipv4(input logic [7:0] proto, input logic [15:0] cks,
                            input logic [15:0] sp, input logic [15:0] dp);
    logic [7:0] h [20] = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00,
                           8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
                           8'hC0, 8'hA8, 8'h00, 8'hC7};
    clear_frame();
    set_macs();
    set_ethertype(16'h0800);
    for (int k = 0; k < 20; k++) set_byte(14 + k, h[k]);
    set_byte(23, proto);
    set_byte(24, cks[15:8]);
    set_byte(25, cks[7:0]);
    set_byte(34, sp[15:8]);
    set_byte(35, sp[7:0]);
    set_byte(36, dp[15:8]);
    set_byte(37, dp[7:0]);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns after the next falling edge.
  task automatic drive_frame(input logic v4, input logic ok, input logic udp,
                             input logic [15:0] sp, input logic [15:0] dp);
    eth_frame   = frame_buf;
    frame_valid = 1'b1;
    exp_count   = exp_count + 32'd1;
    exp_q.push_back({v4, ok, udp, sp, dp, exp_count});
    @(negedge main_clk);
  endtask

  task automatic idle(input int n);
    frame_valid = 1'b0;
    repeat (n) @(negedge main_clk);
  endtask

  // Reference classification of frame_buf, then drive it.
  task automatic drive_model();
    logic v4, ok, udp;
    logic [15:0] sp, dp;
    v4 = ({get_byte(12), get_byte(13)} == 16'h0800);
    ok = v4 && (get_byte(14) == 8'h45);
`ifdef UDP_MAIN_CSUM_EN
    ok = ok && (hdr_sum() == 16'hFFFF);
`endif
    udp = ok && (get_byte(23) == 8'd17);
    sp  = udp ? {get_byte(34), get_byte(35)} : 16'h0;
    dp  = udp ? {get_byte(36), get_byte(37)} : 16'h0;
    drive_frame(v4, ok, udp, sp, dp);
  endtask

  task automatic build_random();
    clear_frame();
    for (int k = 0; k < 64; k++) set_byte(k, 8'($urandom_range(0, 255)));
    set_byte(FW/8 - 1, 8'($urandom_range(0, 255)));
    case ($urandom_range(0, 3))
      0:       set_ethertype(16'h0806);
      3:       set_ethertype(16'($urandom_range(0, 65535)));
      default: set_ethertype(16'h0800);
    endcase
    if ($urandom_range(0, 3) != 0) set_byte(14, 8'h45);
    if ($urandom_range(0, 2) != 0) set_byte(23, 8'd17);
    if ($urandom_range(0, 3) != 0) fix_checksum();
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge main_clk);
    #2;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("result_valid", result_valid, 1);
        check("valid_ipv4",   valid_ipv4,   mon_e[66]);
        check("ip_hdr_ok",    ip_hdr_ok,    mon_e[65]);
        check("is_udp",       is_udp,       mon_e[64]);
        check("udp_src_port", udp_src_port, mon_e[63:48]);
        check("udp_dst_port", udp_dst_port, mon_e[47:32]);
        check("frame_count",  frame_count,  mon_e[31:0]);
        exp_src = mon_e[63:48];
        exp_dst = mon_e[47:32];
      end else begin
        check("idle_result_valid", result_valid, 0);
        check("idle_valid_ipv4",   valid_ipv4,   0);
        check("idle_ip_hdr_ok",    ip_hdr_ok,    0);
        check("idle_is_udp",       is_udp,       0);
        check("idle_src_hold",     udp_src_port, exp_src);
        check("idle_dst_hold",     udp_dst_port, exp_dst);
        check("idle_count_hold",   frame_count,  exp_count);
      end
      check("frame_ready", frame_ready, 1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    main_rst    = 1'b0;
    frame_valid = 1'b0;
    eth_frame   = '0;

    // Reset state.
    #3;
    check("rst_frame_ready",  frame_ready,  0);
    check("rst_result_valid", result_valid, 0);
    check("rst_valid_ipv4",   valid_ipv4,   0);
    check("rst_ip_hdr_ok",    ip_hdr_ok,    0);
    check("rst_is_udp",       is_udp,       0);
    check("rst_src",          udp_src_port, 0);
    check("rst_dst",          udp_dst_port, 0);
    check("rst_count",        frame_count,  0);

    // Frame offered during reset is dropped.
    @(negedge main_clk);
    build_ipv4(8'd17, 16'hB8B8, 16'h1234, 16'h0035);
    eth_frame   = frame_buf;
    frame_valid = 1'b1;
    @(negedge main_clk);
    check("rst_drop_valid", result_valid, 0);
    check("rst_drop_count", frame_count,  0);
    frame_valid = 1'b0;
    main_rst    = 1'b1;
    mon_en      = 1'b1;
    idle(1);

    // EtherType 0x0800, rest zero: IPv4 but bad header.
    clear_frame(); set_macs(); set_ethertype(16'h0800);
    drive_frame(1, 0, 0, 16'h0, 16'h0);
    // ARP.
    clear_frame(); set_macs(); set_ethertype(16'h0806);
    drive_frame(0, 0, 0, 16'h0, 16'h0);
    idle(2);

    // Valid IPv4/UDP with correct checksum.
    build_ipv4(8'd17, 16'hB8B8, 16'h1234, 16'h0035);
    drive_frame(1, 1, 1, 16'h1234, 16'h0035);
    idle(1);

    // Same frame, byte 25 flipped.
    build_ipv4(8'd17, 16'hB847, 16'h1234, 16'h0035);
`ifdef UDP_MAIN_CSUM_EN
    drive_frame(1, 0, 0, 16'h0, 16'h0);
`else
    drive_frame(1, 1, 1, 16'h1234, 16'h0035);
`endif
    idle(1);

    // TCP with correct checksum: header ok, not UDP.
    build_ipv4(8'd6, 16'hB8C3, 16'hBEEF, 16'h0050);
    drive_frame(1, 1, 0, 16'h0, 16'h0);

    // Version 6 nibble: header rejected, valid_ipv4 still set.
    build_ipv4(8'd17, 16'hB8B8, 16'h1234, 16'h0035);
    set_byte(14, 8'h65);
    drive_frame(1, 0, 0, 16'h0, 16'h0);

    // IHL 6: header rejected.
    build_ipv4(8'd17, 16'hB8B8, 16'h1234, 16'h0035);
    set_byte(14, 8'h46);
    drive_frame(1, 0, 0, 16'h0, 16'h0);
    idle(1);

    // Back-to-back IPv4, ARP, IPv4/UDP.
    clear_frame(); set_macs(); set_ethertype(16'h0800);
    drive_frame(1, 0, 0, 16'h0, 16'h0);
    clear_frame(); set_macs(); set_ethertype(16'h0806);
    drive_frame(0, 0, 0, 16'h0, 16'h0);
    build_ipv4(8'd17, 16'hB8B8, 16'hA5A5, 16'h5A5A);
    drive_frame(1, 1, 1, 16'hA5A5, 16'h5A5A);
    idle(2);

    // Random frames with random gaps.
    for (int n = 0; n < 60; n++) begin
      build_random();
      drive_model();
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Reset asserted in the middle of a strobe.
    build_ipv4(8'd17, 16'hB8B8, 16'h1234, 16'h0035);
    drive_frame(1, 1, 1, 16'h1234, 16'h0035);
    mon_en      = 1'b0;
    frame_valid = 1'b0;
    check("pre_rst_strobe", result_valid, 1);
    main_rst = 1'b0;
    #1;
    check("midrst_frame_ready",  frame_ready,  0);
    check("midrst_result_valid", result_valid, 0);
    check("midrst_valid_ipv4",   valid_ipv4,   0);
    check("midrst_ip_hdr_ok",    ip_hdr_ok,    0);
    check("midrst_is_udp",       is_udp,       0);
    check("midrst_src",          udp_src_port, 0);
    check("midrst_dst",          udp_dst_port, 0);
    check("midrst_count",        frame_count,  0);
    exp_count = 32'd0;
    exp_src   = 16'h0;
    exp_dst   = 16'h0;
    @(negedge main_clk);
    main_rst = 1'b1;
    mon_en   = 1'b1;
    clear_frame(); set_macs(); set_ethertype(16'h0806);
    drive_frame(0, 0, 0, 16'h0, 16'h0);
    idle(2);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_main.md
# udp_main

Ingress classifier at the front of the UDP receive path. Accepts one whole Ethernet frame per cycle as a wide, MSB-first vector and flags IPv4 frames (EtherType 0x0800). For IPv4 frames it also validates the IPv4 header, detects UDP and extracts the UDP ports. It feeds the downstream UDP payload logic and keeps a frame counter.

## Interface
- FRAME_WIDTH, default 12000: frame vector width in bits (1500 bytes); must be ≥ 304.
- main_clk  input  1  sole clock; all logic is on the rising edge.
- main_rst  input  1  asynchronous, active-low reset.
- eth_frame  input  FRAME_WIDTH  frame, MSB-first; byte k = eth_frame[FRAME_WIDTH-1-8k -: 8]; byte 0 is the first destination-MAC byte.
- frame_valid  input  1  eth_frame is valid this cycle.
- frame_ready  output  1  block can accept a frame.
- result_valid  output  1  one-cycle strobe; one per accepted frame.
- valid_ipv4  output  1  one-cycle strobe, coincident with result_valid, when the accepted frame's EtherType is 0x0800.
- ip_hdr_ok  output  1  IPv4 header passes the checks; qualified by result_valid.
- is_udp  output  1  UDP datagram detected; qualified by result_valid.
- udp_src_port  output  16  UDP source port; held until next result.
- udp_dst_port  output  16  UDP destination port; held until next result.
- frame_count  output  32  count of accepted frames, wraps.

## Operation
- Acceptance: a frame is accepted on the rising edge where frame_valid && frame_ready.
- frame_ready is 1 in every cycle main_rst is deasserted. There is no backpressure: one frame per cycle is accepted back-to-back.
- Field offsets:
  - EtherType = bytes 12–13.
  - IPv4 header starts at byte 14: version = byte14[7:4], IHL = byte14[3:0], protocol = byte 23, header checksum = bytes 24–25.
  - UDP source port = bytes 34–35; destination port = bytes 36–37.
- ipv4_hit = (EtherType == 16'h0800). valid_ipv4 depends only on the EtherType; the header contents do not affect it.
- ip_hdr_ok = ipv4_hit && version == 4 && IHL == 5, plus the checksum check when enabled (see Configuration).
  - Checksum check: the ones'-complement sum of the ten 16-bit header words, with end-around carry folded, equals 16'hFFFF.
- is_udp = ip_hdr_ok && protocol == 8'd17.
- Ports: udp_src_port and udp_dst_port load the extracted values when is_udp; otherwise they load 0.
- Non-IPv4 frames (e.g. ARP 0x0806): result_valid=1, valid_ipv4=0, ip_hdr_ok=0, is_udp=0, ports load 0.
- frame_count increments by 1 per accepted frame and wraps from 2^32-1 to 0.
- No field beyond byte 37 is inspected. Bits below byte 37 are ignored.

## Timing
- Latency is one cycle. A frame accepted at edge N drives result_valid, valid_ipv4, ip_hdr_ok, is_udp, the ports and frame_count from edge N to edge N+1.
- result_valid and valid_ipv4 are 0 in any cycle that follows an edge with no acceptance. ip_hdr_ok and is_udp are also cleared to 0 in those cycles.
- udp_src_port, udp_dst_port and frame_count hold their values between accepted frames.
- Back-to-back frames produce back-to-back strobes, each reflecting its own frame.
- Reset (main_rst=0, asynchronous): frame_ready=0, result_valid=0, valid_ipv4=0, ip_hdr_ok=0, is_udp=0, udp_src_port=0, udp_dst_port=0, frame_count=0.
- Reset asserted during a strobe cycle clears it immediately.
- Reset release: the first acceptance is possible on the first rising edge after main_rst=1 is seen. A frame presented with frame_valid during reset is dropped, not queued.
- The classification and checksum datapath is combinational from eth_frame and must close timing in a single cycle.

## Configuration
- UDP_MAIN_CSUM_EN defined: ip_hdr_ok additionally requires a correct IPv4 header checksum.
- UDP_MAIN_CSUM_EN undefined: the checksum logic is not built. ip_hdr_ok = ipv4_hit && version==4 && IHL==5, regardless of checksum bytes.
- All other behaviour is identical in both builds.

## Test plan
- Reset pulse, then frame with dst AA:BB:CC:DD:EE:FF, src 11:22:33:44:55:66, EtherType 0x0800, rest zero, frame_valid for one cycle -> next cycle result_valid=1, valid_ipv4=1, ip_hdr_ok=0, is_udp=0, frame_count=1.
- Same MACs, EtherType 0x0806, rest zero -> result_valid=1, valid_ipv4=0, ip_hdr_ok=0, frame_count=2; the following cycle all strobes are 0.
- Valid IPv4 header 45 00 00 1C 00 00 40 00 40 11 + correct checksum, UDP ports 0x1234 -> 0x0035 -> valid_ipv4=1, ip_hdr_ok=1, is_udp=1, udp_src_port=16'h1234, udp_dst_port=16'h0035.
- Same frame with checksum byte 25 flipped -> ip_hdr_ok=0, is_udp=0 with UDP_MAIN_CSUM_EN defined; ip_hdr_ok=1, is_udp=1 without it.
- Three frames on consecutive cycles (IPv4, ARP, IPv4) -> three consecutive result_valid strobes with valid_ipv4 = 1, 0, 1; frame_count advances by 3.
- main_rst driven low mid-strobe -> all outputs 0 at once, frame_ready=0; after release, frame_count restarts from 0.
